ecc_page_scheduler: RTL and testbench
=====================================

ECC_PAGE_SCHEDULER -- requirements
Module: ecc_page_scheduler

Interface
REQ-001 SHALL have parameter PAGE_W, default 11, page address width.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, minimum idle cycles between pages at the decoder input; legal range 2..15.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  4  per-port page read request, level.
REQ-006 SHALL have port req_page  input  4*PAGE_W  page address per port; port i occupies bits [i*PAGE_W +: PAGE_W].
REQ-007 SHALL have port req_last  input  4  per-port flag: requested page is the last page of its packet.
REQ-008 SHALL have port grant  output  4  one-hot, one-cycle acceptance pulse.
REQ-009 SHALL have port sram_rd_en  output  1  SRAM read strobe.
REQ-010 SHALL have port sram_rd_addr  output  PAGE_W+3  {page, half-word index[2:0]}.
REQ-011 SHALL have port sram_rd_data  input  16  read data, one cycle after sram_rd_en.
REQ-012 SHALL have port ecc_rd_data  input  8  page ECC code, valid with read data of half-word 7.
REQ-013 SHALL have port dec_batch  output  4  decoder slice number; 8 = idle.
REQ-014 SHALL have port dec_data  output  16  decoder data, equal to sram_rd_data.
REQ-015 SHALL have port dec_ecc  output  8  decoder ECC code, equal to ecc_rd_data.
REQ-016 SHALL have port dec_eop  output  1  decoder end_of_packet pulse.
REQ-017 SHALL have ports out_port (output, 2, owner of the decoder output stream) and out_valid (output, 1, decoder output slice valid).
REQ-018 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement states IDLE, ISSUE, GAP.
REQ-020 SHALL arbitrate in IDLE, and in the last GAP cycle, whenever any req is high; grant pulses that cycle; req_page and req_last of the winner are latched; the next state is ISSUE.
REQ-021 SHALL, in ISSUE, assert sram_rd_en for exactly 8 consecutive cycles with index 0..7; after index 7 the next state is GAP.
REQ-022 SHALL drive dec_batch with the index issued in the previous cycle, and 8 in every cycle after a non-read cycle.
REQ-023 SHALL hold GAP for GAP_CYCLES cycles; if no req is high in the last GAP cycle, the next state is IDLE.
REQ-024 SHALL, with T the cycle where dec_batch==7, drive out_valid=1 and out_port=owner for cycles T+2..T+9.
REQ-025 SHALL pulse dec_eop at cycle T+10 only if the latched req_last was 1.
REQ-026 SHALL track out_port/out_valid/dec_eop of the previous page independently of the ISSUE state of the next page.
REQ-027 SHALL ignore req deassertion after grant; the grant is committed once given.
REQ-028 SHALL ignore req high on a port that was just granted, unless it is still high at the next arbitration point, where it counts as a new request.
REQ-029 SHALL give back-to-back pages T' = T + GAP_CYCLES + 8.

Reset
REQ-030 SHALL, on rst, go to IDLE and hold all outputs at reset values: grant=0, sram_rd_en=0, sram_rd_addr=0, dec_batch=8, dec_eop=0, out_valid=0, out_port=0, busy=0; the round-robin pointer resets to port 0.
REQ-031 SHALL, on rst mid-page, abort that page immediately, with no dec_eop and no out_valid for it.

Configuration
REQ-032 SHALL use ECC_SCHED_RR_EN as its one compile-time option: when defined, round-robin; priority starts at the port after the last granted port.
REQ-033 SHALL, when ECC_SCHED_RR_EN is not defined, use fixed priority, port 0 highest, port 3 lowest.

Verification
REQ-034 SHALL cover: single req[2], page 0x05A, req_last=1 -> grant=4'b0100; sram_rd_addr 0x2D0..0x2D7 over 8 cycles; dec_batch 0..7 then 8; out_port=2 valid T+2..T+9; dec_eop at T+10.
REQ-035 SHALL cover: req=4'b1111 held, ECC_SCHED_RR_EN defined -> grant order 0,1,2,3,0; dec_batch==7 cycles spaced exactly 10 apart.
REQ-036 SHALL cover: same stimulus, macro undefined -> every grant=4'b0001 while req[0] is held.
REQ-037 SHALL cover: req_last=0 -> no dec_eop; out_valid still 8 cycles.
REQ-038 SHALL cover: rst at ISSUE index 4 -> next cycle sram_rd_en=0, dec_batch=8, busy=0; no out_valid or dec_eop follows.
REQ-039 SHALL cover: req[1] pulsed for one cycle in IDLE -> full 8-read page still issued; grant pulses once.

Source files
------------

// File: rtl/ecc_page_scheduler.sv
// ecc_page_scheduler: arbitrates four page-read ports, streams each granted
// page out of SRAM as eight 16-bit half-words, and tracks the decoder output
// window (out_valid / out_port / dec_eop) of each page after its last read.
// Compile-time option: ECC_SCHED_RR_EN selects round-robin arbitration
// (priority starts after the last granted port); otherwise port 0 always wins.
module ecc_page_scheduler #(
  parameter int PAGE_W     = 11,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*PAGE_W-1:0]   req_page,
  input  logic [3:0]            req_last,
  output logic [3:0]            grant,
  output logic                  sram_rd_en,
  output logic [PAGE_W+2:0]     sram_rd_addr,
  input  logic [15:0]           sram_rd_data,
  input  logic [7:0]            ecc_rd_data,
  output logic [3:0]            dec_batch,
  output logic [15:0]           dec_data,
  output logic [7:0]            dec_ecc,
  output logic                  dec_eop,
  output logic [1:0]            out_port,
  output logic                  out_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [3:0]        gap_q, gap_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic              last_q, last_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;

  // Output-window tracker: runs on its own so the next page can already be
  // issuing while the previous page's decoder output is still being reported.
  logic [3:0]        batch_q;
  logic [3:0]        ocnt_q;
  logic [1:0]        oport_q;
  logic              olast_q;

  logic              arb_point;
  logic              win_any;
  logic [1:0]        win_idx;
  logic [1:0]        cand;
  logic [PAGE_W-1:0] port_page [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_page
    assign port_page[gi] = req_page[gi*PAGE_W +: PAGE_W];
  end

  // Arbiter: pick the winning requester for the current cycle.
  always_comb begin
    win_any = 1'b0;
    win_idx = 2'd0;
    cand    = 2'd0;
`ifdef ECC_SCHED_RR_EN
    // Scan from the farthest offset down so the nearest port after the
    // pointer is the one left standing.
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr_q + 2'(k);
      if (req[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
`else
    for (int k = 3; k >= 0; k--) begin
      cand = 2'(k);
      if (req[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
`endif
  end

  // Next-state logic and grant generation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    page_d    = page_q;
    last_d    = last_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    grant     = 4'b0000;
    arb_point = (state_q == S_IDLE) ||
                ((state_q == S_GAP) && (gap_q == 4'(GAP_CYCLES - 1)));

    case (state_q)
      S_ISSUE: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = S_GAP;
          gap_d   = 4'd0;
        end
      end
      S_GAP: begin
        gap_d = gap_q + 4'd1;
        if (gap_q == 4'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    // A grant is committed the moment it is given; the winner's page and
    // last flag are captured so later req changes cannot affect the page.
    if (arb_point && win_any && !rst) begin
      grant    = 4'b0001 << win_idx;
      state_d  = S_ISSUE;
      idx_d    = 3'd0;
      page_d   = port_page[win_idx];
      last_d   = req_last[win_idx];
      owner_d  = win_idx;
      rr_ptr_d = win_idx + 2'd1;
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      gap_q    <= 4'd0;
      page_q   <= '0;
      last_q   <= 1'b0;
      owner_q  <= 2'd0;
      rr_ptr_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      page_q   <= page_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Decoder slice pipeline and output-window counter (1..10 after T).
  always_ff @(posedge clk) begin
    if (rst) begin
      batch_q <= 4'd8;
      ocnt_q  <= 4'd0;
      oport_q <= 2'd0;
      olast_q <= 1'b0;
    end else begin
      batch_q <= sram_rd_en ? {1'b0, idx_q} : 4'd8;
      if (batch_q == 4'd7) begin
        ocnt_q  <= 4'd1;
        oport_q <= owner_q;
        olast_q <= last_q;
      end else if (ocnt_q == 4'd10) begin
        ocnt_q <= 4'd0;
      end else if (ocnt_q != 4'd0) begin
        ocnt_q <= ocnt_q + 4'd1;
      end
    end
  end

  assign sram_rd_en   = (state_q == S_ISSUE) && !rst;
  assign sram_rd_addr = sram_rd_en ? {page_q, idx_q} : '0;
  assign dec_batch    = rst ? 4'd8 : batch_q;
  assign dec_data     = sram_rd_data;
  assign dec_ecc      = ecc_rd_data;
  assign out_valid    = !rst && (ocnt_q >= 4'd2) && (ocnt_q <= 4'd9);
  assign out_port     = rst ? 2'd0 : oport_q;
  assign dec_eop      = !rst && (ocnt_q == 4'd10) && olast_q;
  assign busy         = !rst && (state_q != S_IDLE);

endmodule

// File: tb/tb_ecc_page_scheduler.sv
// Bench for ecc_page_scheduler: directed scenarios followed by random traffic,
// all checked against a timeline model that books each granted page's
// expected reads, slices, output window and eop into per-cycle arrays.
module tb_ecc_page_scheduler;
  localparam int PW   = 11;
  localparam int GAP  = 2;
  localparam int MAXC = 4096;

  logic              clk;
  logic              rst;
  logic [3:0]        req;
  logic [4*PW-1:0]   req_page;
  logic [3:0]        req_last;
  logic [3:0]        grant;
  logic              sram_rd_en;
  logic [PW+2:0]     sram_rd_addr;
  logic [15:0]       sram_rd_data;
  logic [7:0]        ecc_rd_data;
  logic [3:0]        dec_batch;
  logic [15:0]       dec_data;
  logic [7:0]        dec_ecc;
  logic              dec_eop;
  logic [1:0]        out_port;
  logic              out_valid;
  logic              busy;

  ecc_page_scheduler #(.PAGE_W(PW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_page(req_page), .req_last(req_last),
    .grant(grant), .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
    .sram_rd_data(sram_rd_data), .ecc_rd_data(ecc_rd_data),
    .dec_batch(dec_batch), .dec_data(dec_data), .dec_ecc(dec_ecc),
    .dec_eop(dec_eop), .out_port(out_port), .out_valid(out_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Per-cycle expected outputs.
  logic [3:0]    e_grant [MAXC];
  logic          e_rden  [MAXC];
  logic [PW+2:0] e_addr  [MAXC];
  logic [3:0]    e_batch [MAXC];
  logic          e_valid [MAXC];
  logic [1:0]    e_port  [MAXC];
  logic          e_eop   [MAXC];
  logic          e_busy  [MAXC];

  int free_at   = 0;   // first cycle at which the scheduler may arbitrate
  int last_port = 3;   // so the round-robin search starts at port 0

  int grant_cnt, rden_cnt, valid_cnt, eop_cnt;
  int b7_q[$];

  function automatic void clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      e_grant[i] = 4'd0;
      e_rden[i]  = 1'b0;
      e_addr[i]  = '0;
      e_batch[i] = 4'd8;
      e_valid[i] = 1'b0;
      e_port[i]  = 2'd0;
      e_eop[i]   = 1'b0;
      e_busy[i]  = 1'b0;
    end
  endfunction

  function automatic int pick(input logic [3:0] r);
`ifdef ECC_SCHED_RR_EN
    for (int i = 1; i <= 4; i++) begin
      int p;
      p = (last_port + i) % 4;
      if (r[p]) return p;
    end
`else
    for (int i = 0; i < 4; i++) begin
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: a grant at cycle g books reads at g+1..g+8, slices at
  // g+2..g+9 (T = g+9), output window T+2..T+9, eop at T+10, busy g+1..g+8+GAP.
  task automatic model_cycle();
    int p;
    logic [PW-1:0] pg;
    if (rst) begin
      clear_from(cyc);
      free_at   = cyc + 1;
      last_port = 3;
    end else if (cyc >= free_at && req != 4'd0) begin
      p  = pick(req);
      pg = req_page[p*PW +: PW];
      e_grant[cyc] = 4'(1 << p);
      for (int k = 0; k < 8; k++) begin
        e_rden[cyc+1+k]  = 1'b1;
        e_addr[cyc+1+k]  = {pg, 3'(k)};
        e_batch[cyc+2+k] = 4'(k);
        e_valid[cyc+11+k] = 1'b1;
        e_port[cyc+11+k]  = 2'(p);
      end
      e_eop[cyc+19] = req_last[p];
      for (int c = cyc + 1; c <= cyc + 8 + GAP; c++) e_busy[c] = 1'b1;
      free_at   = cyc + 8 + GAP;
      last_port = p;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    check("grant", 32'(grant), 32'(e_grant[cyc]));
    check("sram_rd_en", 32'(sram_rd_en), 32'(e_rden[cyc]));
    if (e_rden[cyc]) check("sram_rd_addr", 32'(sram_rd_addr), 32'(e_addr[cyc]));
    check("dec_batch", 32'(dec_batch), 32'(e_batch[cyc]));
    check("out_valid", 32'(out_valid), 32'(e_valid[cyc]));
    if (e_valid[cyc]) check("out_port", 32'(out_port), 32'(e_port[cyc]));
    check("dec_eop", 32'(dec_eop), 32'(e_eop[cyc]));
    check("busy", 32'(busy), 32'(e_busy[cyc]));
    check("dec_data", 32'(dec_data), 32'(sram_rd_data));
    check("dec_ecc", 32'(dec_ecc), 32'(ecc_rd_data));
    if (grant != 4'd0) grant_cnt++;
    if (sram_rd_en) rden_cnt++;
    if (out_valid) valid_cnt++;
    if (dec_eop) eop_cnt++;
    if (dec_batch == 4'd7) b7_q.push_back(cyc);
    $display("[TB] cyc=%0d req=%b grant=%b rd_en=%0d addr=%0h batch=%0d valid=%0d port=%0d eop=%0d busy=%0d",
             cyc, req, grant, sram_rd_en, sram_rd_addr, dec_batch, out_valid, out_port, dec_eop, busy);
    @(posedge clk);
    #1;
    cyc++;
    sram_rd_data = 16'($urandom);
    ecc_rd_data  = 8'($urandom);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic set_port(input int p, input logic [PW-1:0] pg, input logic last);
    req_page[p*PW +: PW] = pg;
    req_last[p]          = last;
  endtask

  task automatic zero_counts();
    grant_cnt = 0;
    rden_cnt  = 0;
    valid_cnt = 0;
    eop_cnt   = 0;
    b7_q.delete();
  endtask

  initial begin
    clear_from(0);
    rst          = 1'b1;
    req          = 4'd0;
    req_page     = '0;
    req_last     = 4'd0;
    sram_rd_data = 16'd0;
    ecc_rd_data  = 8'd0;
    zero_counts();
    @(posedge clk);
    #1;

    // Reset state.
    run(2);
    rst = 1'b0;
    run(2);

    // Single request on port 2, page 0x05A, last page of packet.
    zero_counts();
    set_port(2, 11'h05A, 1'b1);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    run(24);
    check("p2_grants", 32'(grant_cnt), 32'd1);
    check("p2_reads", 32'(rden_cnt), 32'd8);
    check("p2_valid", 32'(valid_cnt), 32'd8);
    check("p2_eop", 32'(eop_cnt), 32'd1);

    // Not-last page: no eop, output window still eight cycles.
    zero_counts();
    set_port(0, 11'($urandom), 1'b0);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    run(24);
    check("nolast_eop", 32'(eop_cnt), 32'd0);
    check("nolast_valid", 32'(valid_cnt), 32'd8);

    // One-cycle pulse on req[1]: whole page still issued, one grant.
    zero_counts();
    set_port(1, 11'($urandom), 1'b1);
    req = 4'b0010;
    tick();
    req = 4'b0000;
    run(24);
    check("pulse_grants", 32'(grant_cnt), 32'd1);
    check("pulse_reads", 32'(rden_cnt), 32'd8);

    // All ports held: order depends on the arbitration option; pages spaced GAP+8.
    zero_counts();
    for (int p = 0; p < 4; p++) set_port(p, 11'($urandom), 1'b1);
    req = 4'b1111;
    run(60);
    req = 4'b0000;
    run(30);
    check("held_pages", 32'(b7_q.size()), 32'd6);
    for (int i = 1; i < b7_q.size(); i++)
      check("held_spacing", 32'(b7_q[i] - b7_q[i-1]), 32'(GAP + 8));

    // Reset while index 4 is being read: page aborted, nothing reported.
    set_port(3, 11'($urandom), 1'b1);
    req = 4'b1000;
    tick();
    req = 4'b0000;
    run(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    zero_counts();
    run(25);
    check("abort_valid", 32'(valid_cnt), 32'd0);
    check("abort_eop", 32'(eop_cnt), 32'd0);
    check("abort_reads", 32'(rden_cnt), 32'd0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      for (int p = 0; p < 4; p++) set_port(p, 11'($urandom), 1'($urandom));
      req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    req = 4'b0000;
    run(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
